// File: rtl/trace_mon_pkg.sv
// trace_mon_pkg: shared types and defaults for the trace monitor.
// Build option: TRACE_MON_CHAIN_CHECK_EN enables the x/y/z chain check.
package trace_mon_pkg;

   localparam int DEPTH_DEF = 8;   // FIFO entries (power of two, 2..64)
   localparam int TW_DEF    = 16;  // timestamp width
   localparam int DW        = 32;  // watched value width
   localparam int DROP_W    = 16;  // drop counter width

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_e;

   // Entry layout at the default timestamp width. The top rebuilds the same
   // layout at its own TW and drops chain_err when the check is disabled.
   typedef struct packed {
      logic [TW_DEF-1:0] tstamp;
      logic [DW-1:0]     x;
      logic [DW-1:0]     y;
      logic [DW-1:0]     z;
      logic              chain_err;
   } trace_entry_t;

   // The stimulus chain should satisfy y = x+1 and z = y+1 (32-bit wrap).
   function automatic logic chain_broken(input logic [DW-1:0] x,
                                         input logic [DW-1:0] y,
                                         input logic [DW-1:0] z);
      return (y != x + 32'd1) || (z != y + 32'd1);
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO of packed trace entries.
// Supports a push and a pop in the same cycle, including when full.
module trace_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty.
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A pop frees the slot the push needs, so full only blocks a lone push.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   // Pointer registers with synchronous reset.
   // NOTE: non-blocking assignments in clocked blocks so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage write.
   // NOTE: storage is deliberately not reset; the pointers define what is
   // valid and the top masks the head while empty, so a reset here would only
   // add a reset net to every bit of the array.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/trace_monitor.sv
// trace_monitor: samples x/y/z every clock and queues a timestamped snapshot
// whenever any of them changes; a valid/ready reader drains the queue.
// Build option: TRACE_MON_CHAIN_CHECK_EN stores a per-entry chain check
// (y == x+1, z == y+1); without it out_chain_err is tied low.
module trace_monitor
   import trace_mon_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int TW    = TW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              clr_ovf,
   input  logic [DW-1:0]     x_in,
   input  logic [DW-1:0]     y_in,
   input  logic [DW-1:0]     z_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [TW-1:0]     out_time,
   output logic [DW-1:0]     out_x,
   output logic [DW-1:0]     out_y,
   output logic [DW-1:0]     out_z,
   output logic              out_chain_err,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_cnt
);

   typedef struct packed {
      logic [TW-1:0] tstamp;
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      logic [DW-1:0] z;
`ifdef TRACE_MON_CHAIN_CHECK_EN
      logic          chain_err;
`endif
   } entry_t;

   localparam int EW = $bits(entry_t);

   state_e            state_q, state_d;
   logic [TW-1:0]     ts_q, ts_d;
   logic [DW-1:0]     shx_q, shy_q, shz_q;
   logic [DW-1:0]     shx_d, shy_d, shz_d;
   logic              ovf_q, ovf_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic   capture, shadow_we, changed;
   logic   fifo_full, fifo_empty, pop, drop;
   entry_t wr_entry, head;
   logic [EW-1:0] fifo_rdata;

   // ---------------- FSM ----------------

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   // NOTE: every variable assigned in a combinational block gets a default
   // first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enable) state_d = PRIME;
         PRIME:   state_d = enable ? RUN : IDLE;
         RUN:     if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: PRIME snapshots unconditionally, RUN only on a change.
   always_comb begin
      capture   = 1'b0;
      shadow_we = 1'b0;
      unique case (state_q)
         PRIME: begin
            capture   = 1'b1;
            shadow_we = 1'b1;
         end
         RUN: begin
            capture   = changed;
            shadow_we = 1'b1;
         end
         default: ;
      endcase
   end

   // ---------------- shadows, timestamp ----------------

   assign changed = (x_in != shx_q) || (y_in != shy_q) || (z_in != shz_q);

   assign shx_d = shadow_we ? x_in : shx_q;
   assign shy_d = shadow_we ? y_in : shy_q;
   assign shz_d = shadow_we ? z_in : shz_q;
   assign ts_d  = ts_q + TW'(1);

   // Shadow copies of the last sampled inputs and the free-running timestamp.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shx_q <= '0;
         shy_q <= '0;
         shz_q <= '0;
         ts_q  <= '0;
      end else begin
         shx_q <= shx_d;
         shy_q <= shy_d;
         shz_q <= shz_d;
         ts_q  <= ts_d;
      end
   end

   // ---------------- FIFO and drop accounting ----------------

   // Snapshot of the current sample, stamped with the pre-edge counter.
   always_comb begin
      wr_entry        = '0;
      wr_entry.tstamp = ts_q;
      wr_entry.x      = x_in;
      wr_entry.y      = y_in;
      wr_entry.z      = z_in;
`ifdef TRACE_MON_CHAIN_CHECK_EN
      wr_entry.chain_err = chain_broken(x_in, y_in, z_in);
`endif
   end

   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign drop      = capture && fifo_full && !pop;

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (capture),
      .wdata_i (wr_entry),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Clear first, then a same-cycle drop overrides it and counts as one.
   always_comb begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (clr_ovf) begin
         ovf_d  = 1'b0;
         drop_d = '0;
      end
      if (drop) begin
         ovf_d = 1'b1;
         if (drop_d != '1) drop_d = drop_d + DROP_W'(1);
      end
   end

   // Sticky overflow flag and saturating drop counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end else begin
         ovf_q  <= ovf_d;
         drop_q <= drop_d;
      end
   end

   assign overflow = ovf_q;
   assign drop_cnt = drop_q;

   // ---------------- head outputs ----------------

   assign head     = entry_t'(fifo_rdata);
   assign out_time = out_valid ? head.tstamp : '0;
   assign out_x    = out_valid ? head.x      : '0;
   assign out_y    = out_valid ? head.y      : '0;
   assign out_z    = out_valid ? head.z      : '0;
`ifdef TRACE_MON_CHAIN_CHECK_EN
   assign out_chain_err = out_valid && head.chain_err;
`else
   assign out_chain_err = 1'b0;
`endif

endmodule

// File: tb/tb_trace_monitor.sv
// tb_trace_monitor: directed self-checking bench for trace_monitor.
// A second instance with TW=4 covers timestamp wrap.
module tb_trace_monitor;

`ifdef TRACE_MON_CHAIN_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0, clr_ovf = 1'b0, out_ready = 1'b0;
   logic [31:0] x_in = '0, y_in = '0, z_in = '0;
   logic        out_valid, out_chain_err, overflow;
   logic [15:0] out_time, drop_cnt;
   logic [31:0] out_x, out_y, out_z;

   logic        rst2_n = 1'b0;
   logic        b_en = 1'b0, b_ready = 1'b0;
   logic [31:0] b_x = '0, b_y = '0, b_z = '0;
   logic        b_valid, b_chain, b_ovf;
   logic [3:0]  b_time;
   logic [15:0] b_drop;
   logic [31:0] b_ox, b_oy, b_oz;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   trace_monitor #(.DEPTH(8), .TW(16)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clr_ovf(clr_ovf),
      .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_time(out_time),
      .out_x(out_x), .out_y(out_y), .out_z(out_z),
      .out_chain_err(out_chain_err), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   trace_monitor #(.DEPTH(4), .TW(4)) dut_w (
      .clk(clk), .rst_n(rst2_n), .enable(b_en), .clr_ovf(1'b0),
      .x_in(b_x), .y_in(b_y), .z_in(b_z),
      .out_valid(b_valid), .out_ready(b_ready), .out_time(b_time),
      .out_x(b_ox), .out_y(b_oy), .out_z(b_oz),
      .out_chain_err(b_chain), .overflow(b_ovf), .drop_cnt(b_drop)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   int t0, t200, prev_t;

   initial begin
      tick();
      tick();

      // ---- timestamp wrap on the TW=4 instance ----
      rst2_n = 1'b1; b_en = 1'b1; b_ready = 1'b1;
      b_x = 32'd1; b_y = 32'd2; b_z = 32'd3;
      cyc = 0;
      tick();                                  // edge 0: IDLE -> PRIME
      tick();                                  // edge 1: prime capture
      check("w_prime_valid", b_valid, 1);
      check("w_prime_time", b_time, 1);
      repeat (12) tick();                      // edges 2..13
      check("w_quiet", b_valid, 0);
      b_x = 32'd2;
      tick();                                  // edge 14
      check("w_t14_valid", b_valid, 1);
      check("w_t14_time", b_time, 14);
      repeat (3) tick();                       // edges 15..17
      b_x = 32'd3;
      tick();                                  // edge 18 -> wraps to 2
      check("w_t18_time", b_time, 2);
      check("w_t18_x", b_ox, 3);

      // ---- reset state of main instance ----
      check("rst_valid", out_valid, 0);
      check("rst_time", out_time, 0);
      check("rst_x", out_x, 0);
      check("rst_ovf", overflow, 0);
      check("rst_drop", drop_cnt, 0);

      // ---- prime: one entry 5/6/7 ----
      rst_n = 1'b1; enable = 1'b1; out_ready = 1'b1;
      x_in = 32'd5; y_in = 32'd6; z_in = 32'd7;
      cyc = 0;
      tick();                                  // edge 0: IDLE -> PRIME
      check("prime_wait", out_valid, 0);
      tick();                                  // edge 1: capture
      check("prime_valid", out_valid, 1);
      check("prime_time", out_time, 1);
      check("prime_x", out_x, 5);
      check("prime_y", out_y, 6);
      check("prime_z", out_z, 7);
      check("prime_chain", out_chain_err, 0);
      tick();                                  // edge 2: popped, no change
      check("prime_popped", out_valid, 0);
      repeat (4) begin
         tick();
         check("steady_quiet", out_valid, 0);
      end

      // ---- x steps every 7 cycles ----
      for (int k = 0; k < 3; k++) begin
         x_in = 32'd6 + 32'(k);
         tick();
         check("step_valid", out_valid, 1);
         check("step_x", out_x, 32'd6 + 32'(k));
         check("step_time", out_time, 32'(cyc - 1));
         check("step_chain", out_chain_err, CHK);
         if (k > 0) check("step_delta", out_time - prev_t[15:0], 7);
         prev_t = int'(out_time);
         repeat (6) begin
            tick();
            check("step_quiet", out_valid, 0);
         end
      end

      // ---- overflow: DEPTH+3 changes with reader stalled ----
      out_ready = 1'b0;
      t0 = cyc;
      for (int i = 0; i < 11; i++) begin
         x_in = 32'd100 + 32'(i);
         tick();
      end
      check("ovf_flag", overflow, 1);
      check("ovf_drops", drop_cnt, 3);
      check("ovf_head_x", out_x, 100);
      check("ovf_head_time", out_time, 32'(t0));
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("clr_flag", overflow, 0);
      check("clr_drops", drop_cnt, 0);
      check("clr_head_x", out_x, 100);

      // ---- full FIFO, push and pop in the same cycle ----
      x_in = 32'd200; out_ready = 1'b1;
      t200 = cyc;
      tick();
      check("fullpp_ovf", overflow, 0);
      check("fullpp_drops", drop_cnt, 0);
      for (int i = 1; i < 8; i++) begin
         check("drain_x", out_x, 32'd100 + 32'(i));
         check("drain_time", out_time, 32'(t0 + i));
         tick();
      end
      check("drain_last_valid", out_valid, 1);
      check("drain_last_x", out_x, 200);
      check("drain_last_time", out_time, 32'(t200));
      tick();
      check("empty_valid", out_valid, 0);
      check("empty_x", out_x, 0);
      check("empty_time", out_time, 0);

      // ---- reset with entries pending ----
      out_ready = 1'b0;
      x_in = 32'd300; tick();
      x_in = 32'd301; tick();
      check("pend_valid", out_valid, 1);
      rst_n = 1'b0; enable = 1'b0;
      tick();
      rst_n = 1'b1;
      cyc = 0;
      check("rst2_valid", out_valid, 0);
      check("rst2_x", out_x, 0);
      check("rst2_time", out_time, 0);
      check("rst2_ovf", overflow, 0);
      x_in = 32'd5; y_in = 32'd7; z_in = 32'd8; out_ready = 1'b1;
      tick();                                  // edge 0: IDLE, enable low
      tick();                                  // edge 1
      check("rst2_idle", out_valid, 0);
      enable = 1'b1;
      tick();                                  // edge 2: IDLE -> PRIME
      check("rst2_prime_wait", out_valid, 0);
      tick();                                  // edge 3: capture
      check("rst2_valid_cap", out_valid, 1);
      check("rst2_cap_time", out_time, 3);
      check("rst2_cap_y", out_y, 7);
      check("rst2_chain", out_chain_err, CHK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/trace_monitor.md
# trace_monitor

Synthesizable value-change monitor: samples three 32-bit watched signals every clock, and on any change captures a timestamped snapshot {time, x, y, z} into a small FIFO drained by a valid/ready reader. It is the hardware consumer for the lab stimulus chain (x, y = x+1, z = y+1, periodic x increment), observing those signals on-chip instead of via a simulator print. It sits beside the datapath under test and feeds a debug/trace reader.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- TW, 16: timestamp width.
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- enable  input  1  capture enable.
- clr_ovf  input  1  clears overflow and drop_cnt.
- x_in, y_in, z_in  input  32 each  watched values.
- out_valid  output  1  head entry available.
- out_ready  input  1  reader accepts head.
- out_time  output  TW  timestamp of head entry.
- out_x, out_y, out_z  output  32 each  head snapshot.
- out_chain_err  output  1  chain check result (macro-dependent).
- overflow  output  1  sticky: a capture was dropped.
- drop_cnt  output  16  dropped captures, saturating at 16'hFFFF.

## Operation
- States: IDLE (enable=0), PRIME, RUN. Reset -> IDLE.
- IDLE: no captures; enable=1 -> PRIME next cycle.
- PRIME: capture unconditionally; load shadow registers with x_in/y_in/z_in; -> RUN (-> IDLE if enable=0).
- RUN: capture when any input differs from its shadow; shadows update every RUN cycle; enable=0 -> IDLE.
- Timestamp: free-running TW-bit counter, reset 0, +1 every cycle regardless of state, wraps 2^TW-1 -> 0. An entry records the counter value at the sampling edge.
- Capture with FIFO full and no pop in the same cycle: entry dropped, overflow <= 1, drop_cnt +1 (saturating). Shadows still update.
- Pop: out_valid && out_ready. Full with simultaneous push and pop: both occur, no drop.
- Empty: out_valid=0; out_time/out_x/out_y/out_z/out_chain_err drive 0.
- clr_ovf=1: overflow <= 0, drop_cnt <= 0; a drop in the same cycle wins (overflow=1, drop_cnt=1).
- Reset at any time: FIFO emptied, shadows 0, pending entries lost, state IDLE.

## Timing
- Reset values: out_valid 0, all data outputs 0, overflow 0, drop_cnt 0, timestamp 0.
- Capture latency: change sampled at edge n -> out_valid=1 after edge n (visible in cycle n+1).
- Head outputs are stable while out_valid=1 and out_ready=0.
- Throughput: one push and one pop per cycle.
- out_valid does not depend combinationally on out_ready.

## Configuration
- TRACE_MON_CHAIN_CHECK_EN defined: each captured entry stores chain_err = (y_in != x_in+1) || (z_in != y_in+1), 32-bit wrap arithmetic; out_chain_err reflects the head entry.
- Undefined: no check logic or storage; out_chain_err tied to 0.

## Structure
- Package trace_mon_pkg: state enum (IDLE, PRIME, RUN), packed entry typedef {time, x, y, z, chain_err}, default DEPTH/TW constants.
- Sub-module trace_fifo: parameterized sync FIFO of entries with full/empty, simultaneous push/pop; trace_monitor holds FSM, shadows, timestamp, drop logic.

## Test plan
- Reset then enable=1 with x=5,y=6,z=7 held, out_ready=1 -> exactly one entry, values 5/6/7, time = PRIME cycle count, chain_err=0 (macro on).
- x increments every 7 cycles from 5, y/z static -> one entry per change, consecutive out_time differ by 7, no other entries.
- out_ready=0, DEPTH+3 changes -> DEPTH entries retained in order, overflow=1, drop_cnt=3; clr_ovf -> both 0, entries intact.
- Full FIFO, change with out_ready=1 same cycle -> no drop, count stays DEPTH, oldest popped.
- TW=4, changes at cycles 14 and 18 -> times 14 and 2 (wrap).
- Entries pending, rst_n=0 for one cycle -> out_valid=0, all outputs 0, state IDLE; x=5,y=7,z=8 after re-enable -> chain_err=1 with macro, 0 without.
